uart_cmd_parser: RTL and testbench

//  Byte-level command front end between the UART receiver/transmitter and the SDRAM controller request port.

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_timer.sv | 36 +++
 rtl/uart_cmd_parser.sv | 178 +++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and command opcodes for the UART command parser.
// RESP_16B_EN: when defined, the SEND_HI state exists and reads answer with two bytes.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    ISSUE_WR,
    ISSUE_RD,
    WAIT_RD,
`ifdef RESP_16B_EN
    SEND_HI,
`endif
    SEND_LO
  } state_t;

  localparam logic [7:0] CmdWrite = 8'h77;
  localparam logic [7:0] CmdRead  = 8'h72;

endpackage

// File: rtl/uart_cmd_timer.sv
// Inter-byte / read-return watchdog: clearable, enableable down-counter.
// Clearing reloads Cycles-1, so tc_o fires in the Cycles-th enabled cycle after a clear.
module uart_cmd_timer #(
  parameter int unsigned Cycles = 133000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);
  localparam logic [CntW-1:0] Load = CntW'(Cycles - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == '0);

  // Next count: reload on clear, otherwise count down while enabled and parked at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = Load;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; reset leaves it in the cleared (reloaded) state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= Load;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// UART byte-stream command front end for the SDRAM request port.
// 'w' <addr> <data> issues a write, 'r' <addr> issues a read and returns the data on TX.
// RESP_16B_EN: when defined, read data is returned as high byte then low byte; else low byte only.
//
//  state    | meaning
//  IDLE     | waiting for an opcode byte
//  GET_ADDR | opcode seen, waiting for the address byte (timed)
//  GET_DATA | write address seen, waiting for the data byte (timed)
//  ISSUE_WR | presenting write request until accepted
//  ISSUE_RD | presenting read request until accepted
//  WAIT_RD  | waiting for read return data (timed)
//  SEND_HI  | presenting high response byte (RESP_16B_EN only)
//  SEND_LO  | presenting low response byte
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ClockFreq      = 133_000_000,
  parameter int unsigned SdramAddrWidth = 25,
  parameter int unsigned DataWidth      = 16,
  parameter int unsigned TimeoutUs      = 1000
) (
  input  logic                      i_sys_clk,
  input  logic                      i_rst_n,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready,
  output logic                      o_req_valid,
  input  logic                      i_req_ready,
  output logic                      o_req_we,
  output logic [SdramAddrWidth-1:0] o_req_addr,
  output logic [DataWidth-1:0]      o_req_wdata,
  input  logic                      i_rd_valid,
  input  logic [DataWidth-1:0]      i_rd_data,
  output logic                      o_busy,
  output logic                      o_err
);

  localparam int unsigned TimeoutCycles = ClockFreq / 1_000_000 * TimeoutUs;
`ifdef RESP_16B_EN
  localparam int unsigned RespW = 16;
`else
  localparam int unsigned RespW = 8;
`endif

  state_t           state_q, state_d;
  logic             we_q, we_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [RespW-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             tmr_clr, tmr_en, tmr_tc;

  uart_cmd_timer #(.Cycles(TimeoutCycles)) u_timer (
    .clk_i  (i_sys_clk),
    .rst_ni (i_rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  // Next-state, capture and error logic; a received byte always takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CmdWrite) begin
            we_d    = 1'b1;
            state_d = GET_ADDR;
          end else if (i_rx_data == CmdRead) begin
            we_d    = 1'b0;
            state_d = GET_ADDR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        tmr_en = 1'b1;
        if (i_rx_valid) begin
          addr_d  = i_rx_data;
          state_d = we_q ? GET_DATA : ISSUE_RD;
        end else if (tmr_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      GET_DATA: begin
        tmr_en = 1'b1;
        if (i_rx_valid) begin
          wdata_d = i_rx_data;
          state_d = ISSUE_WR;
        end else if (tmr_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ISSUE_WR: begin
        err_d = i_rx_valid;
        if (i_req_ready) state_d = IDLE;
      end
      ISSUE_RD: begin
        err_d = i_rx_valid;
        if (i_req_ready) state_d = WAIT_RD;
      end
      WAIT_RD: begin
        tmr_en = 1'b1;
        err_d  = i_rx_valid;
        if (i_rd_valid) begin
          rdata_d = i_rd_data[RespW-1:0];
`ifdef RESP_16B_EN
          state_d = SEND_HI;
`else
          state_d = SEND_LO;
`endif
        end else if (tmr_tc) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`ifdef RESP_16B_EN
      SEND_HI: begin
        err_d = i_rx_valid;
        if (i_tx_ready) state_d = SEND_LO;
      end
`endif
      SEND_LO: begin
        err_d = i_rx_valid;
        if (i_tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every state change restarts the watchdog; in the timed states a byte always changes state.
    tmr_clr = (state_d != state_q);
  end

  // State and captured command fields.
  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign o_req_valid = (state_q == ISSUE_WR) || (state_q == ISSUE_RD);
  assign o_req_we    = we_q;
  assign o_req_addr  = SdramAddrWidth'(addr_q);
  assign o_req_wdata = DataWidth'(wdata_q);
  assign o_busy      = (state_q != IDLE);
  assign o_err       = err_q;
`ifdef RESP_16B_EN
  assign o_tx_valid  = (state_q == SEND_HI) || (state_q == SEND_LO);
  assign o_tx_data   = (state_q == SEND_HI) ? rdata_q[15:8] : rdata_q[7:0];
`else
  assign o_tx_valid  = (state_q == SEND_LO);
  assign o_tx_data   = rdata_q;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected requests/TX bytes,
// a negedge monitor compares whatever the DUT presents against the queue heads.
module tb_uart_cmd_parser;

  localparam int unsigned ClockFreq = 1_000_000;
  localparam int unsigned TimeoutUs = 40;
  localparam int unsigned T         = ClockFreq / 1_000_000 * TimeoutUs;
  localparam int AW = 25;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic [7:0]    o_tx_data;
  logic          o_tx_valid;
  logic          i_tx_ready = 1'b0;
  logic          o_req_valid;
  logic          i_req_ready = 1'b0;
  logic          o_req_we;
  logic [AW-1:0] o_req_addr;
  logic [DW-1:0] o_req_wdata;
  logic          i_rd_valid = 1'b0;
  logic [DW-1:0] i_rd_data = '0;
  logic          o_busy;
  logic          o_err;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .ClockFreq(ClockFreq), .SdramAddrWidth(AW), .DataWidth(DW), .TimeoutUs(TimeoutUs)
  ) dut (
    .i_sys_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_req_valid(o_req_valid), .i_req_ready(i_req_ready), .o_req_we(o_req_we),
    .o_req_addr(o_req_addr), .o_req_wdata(o_req_wdata),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data),
    .o_busy(o_busy), .o_err(o_err)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t       req_q[$];
  logic [7:0] tx_q[$];
  logic [15:0] ref_mem[256];
  logic [15:0] sdram_mem[256];

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;
  int req_mode = 0;   // 0: ready high, 1: random, 2: held low
  int tx_mode = 0;
  int rd_delay = 3;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // Ready drivers.
  initial forever begin
    @(posedge clk); #1;
    case (req_mode)
      0: i_req_ready = 1'b1;
      1: i_req_ready = ($urandom_range(0, 2) != 0);
      default: i_req_ready = 1'b0;
    endcase
    case (tx_mode)
      0: i_tx_ready = 1'b1;
      1: i_tx_ready = ($urandom_range(0, 2) != 0);
      default: i_tx_ready = 1'b0;
    endcase
  end

  // SDRAM controller model: stores writes, answers reads after rd_delay cycles.
  initial forever begin
    logic [7:0] a;
    @(negedge clk);
    if (rst_n && o_req_valid && i_req_ready) begin
      a = o_req_addr[7:0];
      if (o_req_we) begin
        sdram_mem[a] = o_req_wdata;
      end else begin
        repeat (rd_delay) @(posedge clk);
        #1;
        i_rd_data  = sdram_mem[a];
        i_rd_valid = 1'b1;
        @(posedge clk); #1;
        i_rd_valid = 1'b0;
        i_rd_data  = DW'($urandom);
      end
    end
  end

  // Monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (o_err) err_seen++;
    if (o_req_valid) begin
      checks++;
      if (req_q.size() == 0) begin
        failures++;
        $display("FAIL req_unexpected actual=we%0b/addr%0h required=no request", o_req_we, o_req_addr);
      end else begin
        check("req_we", o_req_we, req_q[0].we);
        check("req_addr", o_req_addr, req_q[0].addr);
        if (req_q[0].we) check("req_wdata", o_req_wdata, req_q[0].wdata);
        if (i_req_ready) void'(req_q.pop_front());
      end
    end
    if (o_tx_valid) begin
      checks++;
      if (tx_q.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected actual=%0h required=no byte", o_tx_data);
      end else begin
        check("tx_data", o_tx_data, tx_q[0]);
        if (i_tx_ready) void'(tx_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic push_tx(input logic [15:0] d);
`ifdef RESP_16B_EN
    tx_q.push_back(d[15:8]);
`endif
    tx_q.push_back(d[7:0]);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d, input int g);
    req_t r;
    r.we = 1'b1; r.addr = AW'(a); r.wdata = DW'(d);
    req_q.push_back(r);
    ref_mem[a] = DW'(d);
    send_byte(8'h77); gap(g);
    send_byte(a);     gap(g);
    send_byte(d);
  endtask

  task automatic cmd_read(input logic [7:0] a, input int g, input bit expect_data);
    req_t r;
    r.we = 1'b0; r.addr = AW'(a); r.wdata = '0;
    req_q.push_back(r);
    if (expect_data) push_tx(ref_mem[a]);
    send_byte(8'h72); gap(g);
    send_byte(a);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (o_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, o_busy, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    check({name, "_err"}, err_seen, err_exp);
    check({name, "_reqq"}, req_q.size(), 0);
    check({name, "_txq"}, tx_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, n;
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i]   = 16'($urandom);
      sdram_mem[i] = ref_mem[i];
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_tx_data, o_tx_valid, o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_busy, o_err}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    gap(2);

    // Basic write
    cmd_write(8'h05, 8'h17, 0);
    wait_idle("t1", 50);
    check("t1_mem", sdram_mem[5], 16'h0017);

    // Basic read of a known word
    ref_mem[5] = 16'hDEAD; sdram_mem[5] = 16'hDEAD;
    cmd_read(8'h05, 0, 1'b1);
    wait_idle("t2", 50);

    // Backpressure: request held stable for 20 cycles, single accept
    req_mode = 2;
    cmd_write(8'h0F, 8'h9A, 0);
    vc = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_req_valid) vc++;
    end
    check("t3_hold", vc, 20);
    req_mode = 0;
    wait_idle("t3", 50);

    // Inter-byte timeout in GET_DATA
    err_exp++;
    send_byte(8'h77);
    send_byte(8'h05);
    repeat (T - 3) @(negedge clk);
    check("t4_no_early_timeout", o_busy, 1'b1);
    wait_idle("t4", T + 10);
    cmd_read(8'h07, 0, 1'b1);
    wait_idle("t4b", 50);

    // Byte arriving in the last cycle before the timeout wins
    cmd_write(8'h20, 8'h5A, T - 2);
    wait_idle("t4c", 3 * T);

    // Unknown opcode
    err_exp++;
    send_byte(8'h41);
    wait_idle("t5a", 10);

    // Byte dropped during WAIT_RD; read still completes
    rd_delay = 12;
    cmd_read(8'h09, 0, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(o_req_valid && i_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_accept_seen", o_req_valid && i_req_ready, 1'b1);
    err_exp++;
    send_byte(8'h55);
    wait_idle("t5b", 60);

    // Read return too late: timeout, late data ignored
    rd_delay = T + 5;
    err_exp++;
    cmd_read(8'h0C, 0, 1'b0);
    wait_idle("t5c", T + 20);
    gap(T + 10);
    @(posedge clk); #1;
    check("t5c_late_ignored", tx_q.size(), 0);
    check("t5c_err", err_seen, err_exp);

    // Randomized command mix with random backpressure and read latency
    req_mode = 1; tx_mode = 1;
    for (int k = 0; k < 40; k++) begin
      rd_delay = $urandom_range(1, 8);
      a = 8'($urandom_range(0, 15));
      d = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0: begin
          d = 8'($urandom_range(0, 255));
          if (d == 8'h77 || d == 8'h72) d = 8'h41;
          err_exp++;
          send_byte(d);
        end
        1, 2, 3, 4: cmd_write(a, d, $urandom_range(0, 4));
        default:    cmd_read(a, $urandom_range(0, 4), 1'b1);
      endcase
      wait_idle("rand", 300);
    end
    req_mode = 0; tx_mode = 0; rd_delay = 3;

    // Reset while presenting a write request
    req_mode = 2;
    cmd_write(8'h0A, 8'hBB, 0);
    repeat (3) @(negedge clk);
    check("t6_in_issue", o_req_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs",
          {o_tx_data, o_tx_valid, o_req_valid, o_req_we, o_req_addr, o_req_wdata, o_busy, o_err}, 0);
    req_q.delete();
    @(posedge clk); #1;
    req_mode = 0;
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_busy", o_busy, 1'b0);
    @(posedge clk); #1;
    check("t6_err", err_seen, err_exp);
    check("t6_reqq", req_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
